// File: rtl/mvu_pe_popcount_seq_pkg.sv
// ---------------------------------------------------------------------------
// mvu_pe_popcount_seq_pkg
// Shared definitions for the binary-PE popcount sequencer.
//   mvu_pc_state_t : sequencer FSM states
//   calc*          : constant helpers deriving fold counts and widths from the
//                    matrix / SIMD / PE geometry
// ---------------------------------------------------------------------------
package mvu_pe_popcount_seq_pkg;

    // IDLE  : no partial sum and no pending output
    // ACCUM : partial sum held, somewhere inside a synapse fold sequence
    // OUT   : finished vector presented downstream
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } mvu_pc_state_t;

    // Number of synapse folds per output vector
    function automatic int calcSf(input int matrixW, input int simd);
        return matrixW / simd;
    endfunction

    // Number of neuron folds per full matrix
    function automatic int calcNf(input int matrixH, input int pe);
        return matrixH / pe;
    endfunction

    // Width of one lane popcount (range 0..SIMD)
    function automatic int calcCntW(input int simd);
        return $clog2(simd + 1);
    endfunction

    // Accumulator/result width: unsigned 0..MatrixW plus one bit so the
    // bipolar result -MatrixW..+MatrixW fits as a signed value
    function automatic int calcAccW(input int matrixW);
        return $clog2(matrixW + 1) + 1;
    endfunction

    // Counter width for a modulus n, never below one bit
    function automatic int calcCntrW(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mvu_pe_popcount_seq_if.sv
// ---------------------------------------------------------------------------
// mvu_pe_popcount_seq_if
// Beat input, weight address and result output of the popcount sequencer.
//   in_v / in_rdy / in_pc       : popcount beat handshake, lane p at [p*CNT_W +: CNT_W]
//   wmem_addr                   : weight address of the next beat to be accepted
//   out_v / out_rdy / out_acc   : result handshake, lane p at [p*ACC_W +: ACC_W]
// Modports: master drives beats and out_rdy, slave is the sequencer.
// ---------------------------------------------------------------------------
interface mvu_pe_popcount_seq_if
    import mvu_pe_popcount_seq_pkg::*;
#(
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    parameter int MatrixW = 20,
    parameter int MatrixH = 20
) ();

    localparam int CNT_W = calcCntW(SIMD);
    localparam int ACC_W = calcAccW(MatrixW);
    localparam int SF    = calcSf(MatrixW, SIMD);
    localparam int NF    = calcNf(MatrixH, PE);
    localparam int AW    = calcCntrW(SF * NF);

    logic                  in_v;
    logic                  in_rdy;
    logic [PE*CNT_W-1:0]   in_pc;
    logic [AW-1:0]         wmem_addr;
    logic                  out_v;
    logic                  out_rdy;
    logic [PE*ACC_W-1:0]   out_acc;

    modport master (
        output in_v, in_pc, out_rdy,
        input  in_rdy, wmem_addr, out_v, out_acc
    );

    modport slave (
        input  in_v, in_pc, out_rdy,
        output in_rdy, wmem_addr, out_v, out_acc
    );

endinterface

// File: rtl/mvu_pe_popcount_seq_acc.sv
// ---------------------------------------------------------------------------
// mvu_pe_popcount_acc
// One PE lane: accumulates lane popcounts across synapse folds and latches the
// finished (optionally bipolar) result.
//   clk, rst  : clock, asynchronous active-high reset
//   i_accept  : a beat is consumed this cycle
//   i_first   : the beat is fold 0, so the old partial sum is dropped
//   i_last    : the beat is the final fold, so the result register reloads
//   i_pc      : lane popcount of this beat
//   o_acc     : latched result (signed when BIPOLAR)
// ---------------------------------------------------------------------------
module mvu_pe_popcount_acc #(
    parameter int CNT_W   = 2,
    parameter int ACC_W   = 6,
    parameter int MatrixW = 20,
    parameter int BIPOLAR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_accept,
    input  logic             i_first,
    input  logic             i_last,
    input  logic [CNT_W-1:0] i_pc,
    output logic [ACC_W-1:0] o_acc
);

    localparam logic [ACC_W-1:0] MW_C = ACC_W'(MatrixW);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_result;

    // The bipolar mapping 2*acc - MatrixW is done modulo 2^ACC_W; the true
    // result range fits the signed ACC_W range, so the wrap is exact.
    always_comb begin
        w_sum    = (i_first ? '0 : r_acc) + ACC_W'(i_pc);
        w_result = w_sum;
        if (BIPOLAR != 0) begin
            w_result = (w_sum << 1) - MW_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_accept) begin
            r_acc <= w_sum;
            if (i_last) begin
                r_out <= w_result;
            end
        end
    end

    assign o_acc = r_out;

endmodule

// File: rtl/mvu_pe_popcount_seq.sv
// ---------------------------------------------------------------------------
// mvu_pe_popcount_seq
// Sequencer/accumulator for the binary PE datapath of the MVAU. Consumes one
// popcount per lane per beat, accumulates SF folds and emits one result vector
// per neuron fold while generating the weight-memory address.
//   clk, rst : clock, asynchronous active-high reset
//   io_bus   : slave side of mvu_pe_popcount_seq_if (beats in, results out)
// ---------------------------------------------------------------------------
module mvu_pe_popcount_seq
    import mvu_pe_popcount_seq_pkg::*;
#(
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    parameter int MatrixW = 20,
    parameter int MatrixH = 20,
    parameter int BIPOLAR = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mvu_pe_popcount_seq_if.slave  io_bus
);

    localparam int CNT_W = calcCntW(SIMD);
    localparam int ACC_W = calcAccW(MatrixW);
    localparam int SF    = calcSf(MatrixW, SIMD);
    localparam int NF    = calcNf(MatrixH, PE);
    localparam int AW    = calcCntrW(SF * NF);
    localparam int SF_W  = calcCntrW(SF);
    localparam int NF_W  = calcCntrW(NF);

    localparam logic [SF_W-1:0] SF_LAST   = SF_W'(SF - 1);
    localparam logic [NF_W-1:0] NF_LAST   = NF_W'(NF - 1);
    localparam logic [AW-1:0]   ADDR_LAST = AW'(SF * NF - 1);

    if ((MatrixW % SIMD) != 0) begin : g_badMatrixW
        $error("mvu_pe_popcount_seq: MatrixW must be a multiple of SIMD");
    end
    if ((MatrixH % PE) != 0) begin : g_badMatrixH
        $error("mvu_pe_popcount_seq: MatrixH must be a multiple of PE");
    end

    mvu_pc_state_t       r_state;
    mvu_pc_state_t       w_stateNext;
    logic [SF_W-1:0]     r_sf;
    logic [NF_W-1:0]     r_nf;
    logic [AW-1:0]       r_addr;
    logic                w_inRdy;
    logic                w_accept;
    logic                w_first;
    logic                w_last;
    logic [PE*CNT_W-1:0] w_inPc;
    logic [PE*ACC_W-1:0] w_outAcc;

    // While a result is pending, a new beat may only enter when that result
    // leaves in the same cycle; this keeps the output register from being
    // overwritten and lets back-to-back vectors stream without a bubble.
    assign w_inRdy  = (r_state == OUT) ? io_bus.out_rdy : 1'b1;
    assign w_accept = io_bus.in_v && w_inRdy;
    assign w_first  = (r_sf == '0);
    assign w_last   = (r_sf == SF_LAST);
    assign w_inPc   = io_bus.in_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: a final-fold accept always lands in OUT (including the
    // SF==1 case from OUT itself); leaving OUT needs out_rdy.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_stateNext = w_last ? OUT : ACCUM;
                end
            end
            OUT: begin
                if (io_bus.out_rdy) begin
                    if (w_accept) begin
                        w_stateNext = w_last ? OUT : ACCUM;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Fold counters and weight address. The address runs nf*SF+sf in order,
    // so it is kept as its own wrapping counter rather than recomputed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sf   <= '0;
            r_nf   <= '0;
            r_addr <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_sf <= '0;
                r_nf <= (r_nf == NF_LAST) ? '0 : r_nf + 1'b1;
            end else begin
                r_sf <= r_sf + 1'b1;
            end
            r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
        end
    end

    for (genvar p = 0; p < PE; p++) begin : g_lane
        mvu_pe_popcount_acc #(
            .CNT_W   (CNT_W),
            .ACC_W   (ACC_W),
            .MatrixW (MatrixW),
            .BIPOLAR (BIPOLAR)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .i_accept (w_accept),
            .i_first  (w_first),
            .i_last   (w_last),
            .i_pc     (w_inPc[p*CNT_W +: CNT_W]),
            .o_acc    (w_outAcc[p*ACC_W +: ACC_W])
        );
    end

    assign io_bus.in_rdy    = w_inRdy;
    assign io_bus.wmem_addr = r_addr;
    assign io_bus.out_v     = (r_state == OUT);
    assign io_bus.out_acc   = w_outAcc;

endmodule

// File: tb/tb_mvu_pe_popcount_seq.sv
// ---------------------------------------------------------------------------
// tb_mvu_pe_popcount_seq
// Three instances: bipolar SF=3/NF=2, raw (BIPOLAR=0) mirroring the same
// stimulus, and bipolar SF=1. Expected vectors are queued when stimulus is
// issued; monitors pop and compare on each output transfer.
// ---------------------------------------------------------------------------
module tb_mvu_pe_popcount_seq;

    localparam int ACC_W    = 4;
    localparam int ONE_ACCW = 3;

    logic clk;
    logic rst;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [2*ACC_W-1:0]    qMain[$];
    logic [2*ACC_W-1:0]    qRaw[$];
    logic [2*ONE_ACCW-1:0] qOne[$];

    mvu_pe_popcount_seq_if #(.SIMD(2), .PE(2), .MatrixW(6), .MatrixH(4)) bus ();
    mvu_pe_popcount_seq_if #(.SIMD(2), .PE(2), .MatrixW(6), .MatrixH(4)) busRaw ();
    mvu_pe_popcount_seq_if #(.SIMD(2), .PE(2), .MatrixW(2), .MatrixH(4)) busOne ();

    assign busRaw.in_v    = bus.in_v;
    assign busRaw.in_pc   = bus.in_pc;
    assign busRaw.out_rdy = bus.out_rdy;

    mvu_pe_popcount_seq #(.SIMD(2), .PE(2), .MatrixW(6), .MatrixH(4), .BIPOLAR(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    mvu_pe_popcount_seq #(.SIMD(2), .PE(2), .MatrixW(6), .MatrixH(4), .BIPOLAR(0)) dutRaw (
        .clk    (clk),
        .rst    (rst),
        .io_bus (busRaw)
    );

    mvu_pe_popcount_seq #(.SIMD(2), .PE(2), .MatrixW(2), .MatrixH(4), .BIPOLAR(1)) dutOne (
        .clk    (clk),
        .rst    (rst),
        .io_bus (busOne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Queue the hand-computed result of one vector for both SF=3 instances
    task automatic pushExp(input int e0, input int e1, input int r0, input int r1);
        logic [ACC_W-1:0] a0, a1, b0, b1;
        a0 = e0[ACC_W-1:0];
        a1 = e1[ACC_W-1:0];
        b0 = r0[ACC_W-1:0];
        b1 = r1[ACC_W-1:0];
        qMain.push_back({a1, a0});
        qRaw.push_back({b1, b0});
    endtask

    // Present one beat from posedge+1 until accepted, then check the address
    task automatic applyStimulus(input int p0, input int p1, input int expAddr);
        logic accepted;
        int   guard;
        logic [1:0] l0, l1;
        l0 = p0[1:0];
        l1 = p1[1:0];
        bus.in_v  = 1'b1;
        bus.in_pc = {l1, l0};
        guard     = 0;
        accepted  = 1'b0;
        while (!accepted && guard < 50) begin
            @(negedge clk);
            accepted = bus.in_rdy;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!accepted) begin
            checkOutput("beatTimeout", 32'd0, 32'd1);
        end else begin
            checkOutput("wmemAddr", 32'(bus.wmem_addr), 32'(expAddr));
        end
        bus.in_v = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: compare on every output transfer
    always @(negedge clk) begin
        if (!rst && bus.out_v && bus.out_rdy) begin
            if (qMain.size() == 0) begin
                checkOutput("mainUnexpected", 32'(bus.out_acc), 32'hFFFF);
            end else begin
                checkOutput("mainAcc", 32'(bus.out_acc), 32'(qMain.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && busRaw.out_v && busRaw.out_rdy) begin
            if (qRaw.size() == 0) begin
                checkOutput("rawUnexpected", 32'(busRaw.out_acc), 32'hFFFF);
            end else begin
                checkOutput("rawAcc", 32'(busRaw.out_acc), 32'(qRaw.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && busOne.out_v && busOne.out_rdy) begin
            if (qOne.size() == 0) begin
                checkOutput("oneUnexpected", 32'(busOne.out_acc), 32'hFFFF);
            end else begin
                checkOutput("oneAcc", 32'(busOne.out_acc), 32'(qOne.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int oneP0[4]   = '{0, 1, 2, 1};
        int oneP1[4]   = '{2, 2, 0, 1};
        int oneE0[4]   = '{-2, 0, 2, 0};
        int oneE1[4]   = '{2, 2, -2, 0};
        int oneAddr[4] = '{1, 0, 1, 0};

        rst            = 1'b1;
        bus.in_v       = 1'b0;
        bus.in_pc      = '0;
        bus.out_rdy    = 1'b1;
        busOne.in_v    = 1'b0;
        busOne.in_pc   = '0;
        busOne.out_rdy = 1'b1;

        // Reset state
        idleCycles(2);
        checkOutput("rstOutV", 32'(bus.out_v), 32'd0);
        checkOutput("rstAddr", 32'(bus.wmem_addr), 32'd0);
        checkOutput("rstOutAcc", 32'(bus.out_acc), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("relInRdy", 32'(bus.in_rdy), 32'd1);

        // Basic vector: lane0 {2,1,0} -> 0 (raw 3), lane1 {2,2,2} -> +6
        $display("[TB] basic vector");
        pushExp(0, 6, 3, 6);
        applyStimulus(2, 2, 1);
        applyStimulus(1, 2, 2);
        checkOutput("outVEarly", 32'(bus.out_v), 32'd0);
        applyStimulus(0, 2, 3);
        checkOutput("outVLatency", 32'(bus.out_v), 32'd1);
        idleCycles(1);
        checkOutput("outVDrop", 32'(bus.out_v), 32'd0);

        // Stall: lane0 {2,2,1} -> +4, lane1 {0,1,0} -> -4 held with out_rdy low
        $display("[TB] output stall");
        bus.out_rdy = 1'b0;
        pushExp(4, -4, 5, 1);
        applyStimulus(2, 0, 4);
        applyStimulus(2, 1, 5);
        applyStimulus(1, 0, 0);
        pushExp(0, 0, 3, 3);
        bus.in_v  = 1'b1;
        bus.in_pc = {2'd1, 2'd1};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stallOutV", 32'(bus.out_v), 32'd1);
            checkOutput("stallAcc", 32'(bus.out_acc), 32'hC4);
            checkOutput("stallInRdy", 32'(bus.in_rdy), 32'd0);
            checkOutput("stallAddr", 32'(bus.wmem_addr), 32'd0);
        end
        bus.out_rdy = 1'b1;
        @(negedge clk);
        checkOutput("releaseInRdy", 32'(bus.in_rdy), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("releaseAddr", 32'(bus.wmem_addr), 32'd1);
        bus.in_v = 1'b0;

        // All-ones beats: two vectors of 0, address wraps 5 -> 0
        $display("[TB] all-ones vectors");
        applyStimulus(1, 1, 2);
        applyStimulus(1, 1, 3);
        pushExp(0, 0, 3, 3);
        applyStimulus(1, 1, 4);
        applyStimulus(1, 1, 5);
        applyStimulus(1, 1, 0);

        // Bubbles between the beats of the basic vector
        $display("[TB] bubbles");
        pushExp(0, 6, 3, 6);
        applyStimulus(2, 2, 1);
        idleCycles(2);
        checkOutput("bubbleAddr", 32'(bus.wmem_addr), 32'd1);
        applyStimulus(1, 2, 2);
        idleCycles(3);
        applyStimulus(0, 2, 3);
        idleCycles(1);

        // Reset mid-fold, then a fresh vector of 2s -> +6
        $display("[TB] reset mid-fold");
        applyStimulus(1, 1, 4);
        applyStimulus(1, 1, 5);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midRstAddr", 32'(bus.wmem_addr), 32'd0);
        checkOutput("midRstOutV", 32'(bus.out_v), 32'd0);
        idleCycles(1);
        rst = 1'b0;
        #1;
        checkOutput("midRelInRdy", 32'(bus.in_rdy), 32'd1);
        pushExp(6, 6, 6, 6);
        applyStimulus(2, 2, 1);
        applyStimulus(2, 2, 2);
        applyStimulus(2, 2, 3);
        idleCycles(1);

        // Reset while a result is pending: lane0 {1,0,2}, lane1 {0,0,0}
        $display("[TB] reset mid-output");
        bus.out_rdy = 1'b0;
        pushExp(0, -6, 3, 0);
        applyStimulus(1, 0, 4);
        applyStimulus(0, 0, 5);
        applyStimulus(2, 0, 0);
        idleCycles(1);
        checkOutput("pendOutV", 32'(bus.out_v), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("pendRstOutV", 32'(bus.out_v), 32'd0);
        checkOutput("pendRstAcc", 32'(bus.out_acc), 32'd0);
        if (qMain.size() > 0) void'(qMain.pop_back());
        if (qRaw.size() > 0) void'(qRaw.pop_back());
        idleCycles(1);
        rst         = 1'b0;
        bus.out_rdy = 1'b1;
        // lane0 {2,2,2} -> +6, lane1 {1,1,1} -> 0, starting again at address 0
        pushExp(6, 0, 6, 3);
        applyStimulus(2, 1, 1);
        applyStimulus(2, 1, 2);
        applyStimulus(2, 1, 3);
        idleCycles(2);

        // SF=1 instance: continuous beats, one result per cycle, no bubbles
        $display("[TB] single-fold streaming");
        for (int i = 0; i < 4; i++) begin
            logic [1:0]          l0, l1;
            logic [ONE_ACCW-1:0] x0, x1;
            l0 = oneP0[i][1:0];
            l1 = oneP1[i][1:0];
            x0 = oneE0[i][ONE_ACCW-1:0];
            x1 = oneE1[i][ONE_ACCW-1:0];
            qOne.push_back({x1, x0});
            busOne.in_v  = 1'b1;
            busOne.in_pc = {l1, l0};
            @(posedge clk);
            #1;
            checkOutput("oneAddr", 32'(busOne.wmem_addr), 32'(oneAddr[i]));
            checkOutput("oneOutV", 32'(busOne.out_v), 32'd1);
        end
        busOne.in_v = 1'b0;
        idleCycles(1);
        checkOutput("oneDrainOutV", 32'(busOne.out_v), 32'd0);
        idleCycles(2);

        checkOutput("mainQueueEmpty", 32'(qMain.size()), 32'd0);
        checkOutput("rawQueueEmpty", 32'(qRaw.size()), 32'd0);
        checkOutput("oneQueueEmpty", 32'(qOne.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
